// File: rtl/key_event_pkg.sv
// Shared definitions for the button/event path: FSM state codes, the event
// bundle carried between next-state logic and the output registers, and the
// 50 MHz timing constants also consumed by debounce and UART baud logic.
package key_event_pkg;

  // Two-bit state encoding; 2'b11 is unused and recovers to S_IDLE.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HOLD = 2'b01;
  localparam logic [1:0] S_LONG = 2'b10;

  // Cycle counts at a 50 MHz clock.
  localparam int unsigned T_1S    = 50_000_000;
  localparam int unsigned T_200MS = 10_000_000;
  localparam int unsigned T_20MS  = 1_000_000;

  // One bit per event pulse.
  typedef struct packed {
    logic press;
    logic rel;
    logic shrt;
    logic lng;
    logic rep;
  } key_evt_t;

endpackage

// File: rtl/key_event_tick_counter.sv
// Purpose : CW-bit up counter with synchronous clear (priority), enable and
//           terminal-count flag against a runtime limit.
// Latency : o_tc is combinational from the current count; count updates 1 clk.
// Backpr. : none; counter advances whenever i_en is high.
// Ports   : clk, n_rst (async active-low), i_clr, i_en, i_limit[CW-1:0],
//           o_tc (count == limit).
module key_event_tick_counter #(
  parameter int CW = 26
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_limit,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/key_event.sv
// Purpose : turns the debounced button level into one-cycle press, release,
//           short-release, long-press and auto-repeat pulses plus a held flag.
// Latency : every output registered; 1 clk after the edge sampling the cause.
// Backpr. : none; pulses are fire-and-forget to the UART command logic.
// Ports   : clk, n_rst (async active-low), i_btn_level (1 = pressed),
//           o_press_p, o_release_p, o_short_p, o_long_p, o_rep_p, o_held.
module key_event
  import key_event_pkg::*;
#(
  parameter int          CW        = 26,
  parameter logic [CW-1:0] T_LONG  = CW'(T_1S),
  parameter logic [CW-1:0] T_REPEAT = CW'(T_200MS),
  parameter logic        REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_btn_level,
  output logic o_press_p,
  output logic o_release_p,
  output logic o_short_p,
  output logic o_long_p,
  output logic o_rep_p,
  output logic o_held
);

  localparam logic [CW-1:0] LIM_LONG = T_LONG - 1'b1;
  localparam logic [CW-1:0] LIM_REP  = T_REPEAT - 1'b1;

  logic [1:0]    r_state;
  key_evt_t      r_evt;
  logic          r_held;

  logic [1:0]    w_nstate;
  key_evt_t      w_evt;
  logic          w_clr;
  logic          w_en;
  logic          w_tc;
  logic [CW-1:0] w_limit;

  // One shared counter: measures hold time in S_HOLD, repeat period in S_LONG.
  assign w_limit = (r_state == S_LONG) ? LIM_REP : LIM_LONG;

  key_event_tick_counter #(.CW(CW)) u_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_nstate = r_state;
    w_evt    = '0;
    w_clr    = 1'b0;
    w_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (i_btn_level) begin
          w_nstate  = S_HOLD;
          w_evt.press = 1'b1;
        end
      end
      S_HOLD: begin
        // Release is checked first so it wins over reaching the threshold.
        if (!i_btn_level) begin
          w_nstate   = S_IDLE;
          w_evt.rel  = 1'b1;
          w_evt.shrt = 1'b1;
          w_clr      = 1'b1;
        end else if (w_tc) begin
          w_nstate  = S_LONG;
          w_evt.lng = 1'b1;
          w_clr     = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      S_LONG: begin
        if (!i_btn_level) begin
          w_nstate  = S_IDLE;
          w_evt.rel = 1'b1;
          w_clr     = 1'b1;
        end else if (REPEAT_EN) begin
          if (w_tc) begin
            w_evt.rep = 1'b1;
            w_clr     = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end else begin
          w_clr = 1'b1;
        end
      end
      default: begin
        // Unused code: silently return to idle.
        w_nstate = S_IDLE;
        w_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_evt   <= '0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_evt   <= w_evt;
      r_held  <= (w_nstate != S_IDLE);
    end
  end

  assign o_press_p   = r_evt.press;
  assign o_release_p = r_evt.rel;
  assign o_short_p   = r_evt.shrt;
  assign o_long_p    = r_evt.lng;
  assign o_rep_p     = r_evt.rep;
  assign o_held      = r_held;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: two instances (auto-repeat on / off) share one input.
// Expected outputs come from an event-level model that counts sampled edges
// since the press and applies the press/short/long/repeat rules directly.
module tb_key_event;

  localparam int TL = 8;
  localparam int TR = 4;

  logic clk;
  logic n_rst;
  logic i_btn_level;

  logic a_press, a_rel, a_short, a_long, a_rep, a_held;
  logic b_press, b_rel, b_short, b_long, b_rep, b_held;

  int checks;
  int failures;
  int cyc;

  // Model state
  bit  m_active;
  int  m_k;
  logic [5:0] exp_a;
  logic [5:0] exp_b;

  key_event #(.CW(4), .T_LONG(4'd8), .T_REPEAT(4'd4), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .i_btn_level(i_btn_level),
    .o_press_p(a_press), .o_release_p(a_rel), .o_short_p(a_short),
    .o_long_p(a_long), .o_rep_p(a_rep), .o_held(a_held)
  );

  key_event #(.CW(4), .T_LONG(4'd8), .T_REPEAT(4'd4), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .n_rst(n_rst), .i_btn_level(i_btn_level),
    .o_press_p(b_press), .o_release_p(b_rel), .o_short_p(b_short),
    .o_long_p(b_long), .o_rep_p(b_rep), .o_held(b_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (press,rel,short,long,rep,held)", tag, got, exp);
    end
  endtask

  task automatic check_both(input string what);
    chk_eq($sformatf("%s rep_on cyc=%0d", what, cyc),
           {a_press, a_rel, a_short, a_long, a_rep, a_held}, exp_a);
    chk_eq($sformatf("%s rep_off cyc=%0d", what, cyc),
           {b_press, b_rel, b_short, b_long, b_rep, b_held}, exp_b);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    exp_a    = '0;
    exp_b    = '0;
  endtask

  // Expected outputs after one clock edge that samples level b.
  task automatic model_edge(input bit b);
    bit press, rel, shrt, lng, rep;
    press = 0; rel = 0; shrt = 0; lng = 0; rep = 0;
    if (!m_active) begin
      if (b) begin
        press    = 1;
        m_active = 1;
        m_k      = 0;
      end
    end else begin
      m_k++;
      if (!b) begin
        rel      = 1;
        shrt     = (m_k <= TL);
        m_active = 0;
      end else if (m_k == TL) begin
        lng = 1;
      end else if (m_k > TL && ((m_k - TL) % TR) == 0) begin
        rep = 1;
      end
    end
    exp_a = {press, rel, shrt, lng, rep, m_active};
    exp_b = {press, rel, shrt, lng, 1'b0, m_active};
  endtask

  // Called just after a negedge: drive, let one posedge pass, check at next negedge.
  task automatic step(input bit b);
    i_btn_level = b;
    model_edge(b);
    @(negedge clk);
    cyc++;
    check_both("step");
  endtask

  task automatic hold(input int n, input int gap);
    for (int i = 0; i < n; i++) step(1'b1);
    for (int i = 0; i < gap; i++) step(1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    n_rst = 1'b0;
    i_btn_level = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_both("reset");
    n_rst = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) step(1'b0);

    // Short press: 3 high then release
    hold(3, 4);
    // Long press with repeats: 20 high
    hold(20, 4);
    // Release on the same edge the hold threshold would fire
    hold(8, 3);
    // One edge past the threshold: long fires, then release without short
    hold(9, 3);

    // Reset mid-hold, button stays pressed through reset
    hold(10, 0);
    n_rst = 1'b0;
    model_reset();
    #1;
    check_both("rst_mid");
    @(negedge clk);
    check_both("rst_hold1");
    @(negedge clk);
    check_both("rst_hold2");
    n_rst = 1'b1;
    hold(12, 3);

    // Illegal state recovery: no pulses, then normal press detection works
    force dut.r_state = 2'b11;
    step(1'b0);
    release dut.r_state;
    step(1'b0);
    step(1'b0);

    // Fast alternation: press/release every cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      step(1'b0);
    end

    // Randomized holds and gaps
    for (int i = 0; i < 60; i++) begin
      hold($urandom_range(1, 30), $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumes the debounced button level from the debounce stage (50 MHz domain) and turns it into single-cycle event pulses: press, release, short-release, long-press and auto-repeat.
- Feeds the UART command/TX logic, which acts on events rather than raw levels.
- Purely synchronous to clk. The input is already clean and synchronous, so no extra synchronizer is needed.

Parameters:
- CW, 26, width of the hold/repeat counter in bits.
- T_LONG, 26'd50_000_000, hold time in clk cycles before long_p (1 s at 50 MHz). Legal range: 2 <= T_LONG <= 2^CW-1.
- T_REPEAT, 26'd10_000_000, period in clk cycles between rep_p pulses once long (200 ms). Legal range: 2 <= T_REPEAT <= 2^CW-1.
- REPEAT_EN, 1'b1, 1 = auto-repeat enabled; 0 = no rep_p pulses.

Ports:
- clk  in  1  system clock, 50 MHz.
- n_rst  in  1  asynchronous, active-low reset.
- btn_level  in  1  debounced button level, 1 = pressed.
- press_p  out  1  one-cycle pulse on press.
- release_p  out  1  one-cycle pulse on any release.
- short_p  out  1  one-cycle pulse on a release before the long threshold.
- long_p  out  1  one-cycle pulse when the hold reaches T_LONG.
- rep_p  out  1  one-cycle pulse every T_REPEAT cycles after long_p.
- held  out  1  high while the FSM is not in S_IDLE.

Behaviour:
- Reset (async, n_rst=0):
  - state=S_IDLE, cnt=0.
  - All pulse outputs 0, held=0.
- All outputs are registered. Events appear 1 cycle after the clk edge that samples the causing condition. Each pulse lasts exactly 1 cycle.
- States: S_IDLE, S_HOLD, S_LONG. Two-bit encoding; the unused code returns to S_IDLE with all outputs 0.
- S_IDLE:
  - btn_level=1 at an edge -> S_HOLD, cnt<=0, press_p<=1.
  - Otherwise stay.
- S_HOLD:
  - btn_level=0 -> S_IDLE, release_p<=1, short_p<=1.
  - Else if cnt==T_LONG-1 -> S_LONG, cnt<=0, long_p<=1.
  - Else cnt<=cnt+1.
- S_LONG:
  - btn_level=0 -> S_IDLE, release_p<=1 (no short_p).
  - Else if REPEAT_EN and cnt==T_REPEAT-1 -> cnt<=0, rep_p<=1.
  - Else if REPEAT_EN -> cnt<=cnt+1.
  - If REPEAT_EN=0, cnt holds at 0 and no rep_p is ever issued.
- Timing: long_p asserts exactly T_LONG cycles after press_p; successive rep_p pulses are spaced T_REPEAT cycles apart; the first rep_p comes T_REPEAT cycles after long_p.
- held is registered alongside state: 1 in the cycle press_p is high through the cycle before release_p. held=0 in the release_p cycle.
- Simultaneous events:
  - Release and threshold on the same edge: release wins. No long_p/rep_p is issued; the counter resets.
  - Release and a press are never sampled on the same edge, since the input is a single level. Release followed by a press on the next edge is legal: release_p then press_p in consecutive cycles.
- Counter width: cnt is CW bits. Compares are exact-equality against parameter-1 truncated to CW bits. Wrap-around cannot occur within legal parameter ranges.
- Reset mid-hold: everything clears and no release_p is emitted. If btn_level is still 1 after reset, the first edge generates a new press_p.
- The debounce stage resets its output to 0, so no spurious press occurs at power-up.

Decomposition:
- Shared package key_event_pkg holds:
  - state localparams S_IDLE=2'b00, S_HOLD=2'b01, S_LONG=2'b10;
  - 50 MHz timing constants T_1S, T_200MS, T_20MS, also used by debounce and the UART baud logic.
- One sub-module is natural: tick_counter (CW-bit counter with synchronous clear, enable and terminal-count compare against a runtime limit). key_event instantiates one of them, with the limit muxed between T_LONG-1 and T_REPEAT-1 by state.

Test Plan:
Bench parameters: T_LONG=8, T_REPEAT=4, REPEAT_EN=1, CW=4.
- Reset release with btn_level=0 for 10 cycles -> all outputs 0; held=0; no pulses.
- btn_level high for 3 cycles then low -> press_p 1 cycle; 3 cycles later release_p and short_p together for 1 cycle; held high 3 cycles; no long_p.
- btn_level high for 20 cycles then low:
  - press_p at cycle c;
  - long_p at c+8;
  - rep_p at c+12, c+16;
  - release_p at c+20 with short_p=0.
- Release timed on the same edge as cnt==T_LONG-1 (high exactly 8 sampled edges) -> release_p+short_p, no long_p. Then REPEAT_EN=0 with a 20-cycle hold -> long_p at c+8, zero rep_p.
- n_rst asserted at c+10 of a hold, released with btn_level still 1 -> outputs 0 during reset, no release_p, press_p on the first edge after release, long_p 8 cycles later.
- Force the illegal state 2'b11 -> FSM returns to S_IDLE next cycle with no pulse. Then 1-cycle high/low alternation on btn_level -> press_p/release_p alternate every cycle, all single-cycle.
